msrv32_dec_pipe: RTL and testbench
==================================

# msrv32_dec_pipe

Registered, parametrised successor to the msrv32 combinational decoder. It takes the full 32-bit instruction word plus the low immediate-adder bits and produces the same control bundle. The bundle is held in a valid/ready output buffer of configurable depth, so decode sits as a true pipeline stage between fetch and execute. It also flushes on trap, counts accepted illegal instructions, and optionally decodes RV32M.

## Interface
- BUF_DEPTH, 2, output buffer entries; legal values 1 (pipeline register) or 2 (skid buffer).
- CNT_W, 8, width of the saturating illegal-instruction counter.
- ms_riscv32_mp_clk_in  input  1  clock; all state on rising edge.
- ms_riscv32_mp_rst_n_in  input  1  asynchronous, active-low reset.
- instr_in  input  32  instruction word.
- iadder_1_to_0_in  input  2  low bits of the load/store effective address.
- valid_in  input  1  instr_in and iadder_1_to_0_in are valid.
- ready_out  output  1  block accepts the input this cycle.
- trap_taken_in  input  1  flush request.
- valid_out  output  1  control bundle valid.
- ready_in  input  1  downstream accepts the bundle.
- alu_opcode_out  output  4  ALU operation.
- mem_wr_req_out  output  1  store request.
- load_size_out  output  2  load size.
- load_unsigned_out  output  1  unsigned load.
- alu_src_out  output  1  ALU source select.
- iadder_src_out  output  1  immediate-adder base select.
- csr_wr_en_out  output  1  CSR write enable.
- rf_wr_en_out  output  1  register-file write enable.
- wb_mux_sel_out  output  3  writeback source.
- imm_type_out  output  3  immediate format.
- csr_op_out  output  3  CSR operation.
- illegal_instr_out  output  1  illegal instruction.
- misalligned_load_out  output  1  misaligned load.
- misalligned_store_out  output  1  misaligned store.
- muldiv_en_out  output  1  RV32M operation.
- illegal_count_out  output  CNT_W  count of accepted illegal instructions.

## Operation
- **Accept:** a handshake occurs when `valid_in & ready_out & !trap_taken_in`. Decode is combinational on the input; the result is written into the buffer tail.
- **Opcode map (instr[6:2]):** LOAD 00000, MISC_MEM 00011, OP_IMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011, SYSTEM 11100.
- **Illegal:** any other opcode, instr[1:0] != 11, or OP with funct7 not in {0000000, 0100000} (0000001 is also legal when RV32M is enabled).
- **alu_opcode:**
  - OP: {instr[30], funct3}.
  - OP_IMM: {funct3==101 ? instr[30] : 0, funct3}.
  - Otherwise: 0000.
- **load/CSR fields:** load_size = funct3[1:0]; load_unsigned = funct3[2]; csr_op = funct3.
- **alu_src:** 1 only for OP.
- **iadder_src:** 1 for LOAD, STORE and JALR.
- **wb_mux_sel:** ALU 000, LOAD 001, LUI 010, AUIPC 011, SYSTEM 100, JAL/JALR 101.
- **imm_type:** R 000, I 001 (OP_IMM/LOAD/JALR), S 010, B 011, U 100, J 101, CSR 110.
- **Misalignment:**
  - Word access: misaligned when iadder_1_to_0 != 00.
  - Halfword access: misaligned when iadder_1_to_0[0] = 1.
  - misalligned_load applies to LOAD only; misalligned_store applies to STORE only.
- **csr_wr_en:** SYSTEM & funct3 != 000.
- **rf_wr_en:** OP, OP_IMM, LOAD, AUIPC, LUI, JAL, JALR, or SYSTEM with funct3 != 000. Forced to 0 when illegal or misalligned_load.
- **mem_wr_req:** STORE & !misalligned_store & !illegal.
- **Flush:** trap_taken_in invalidates every buffer entry at the next edge and discards the same-cycle input.
- **Illegal counter:** +1 per accepted illegal instruction. Saturates at 2^CNT_W-1. Not cleared by flush; cleared only by reset.

## Timing
- **Reset (asynchronous):** valid_out=0, ready_out=1, all bundle outputs 0, illegal_count_out=0.
- **Latency:** 1 cycle from accept to valid_out.
- **Hold:** the bundle stays stable while `valid_out & !ready_in`.
- **BUF_DEPTH=1:** ready_out = !valid_out | ready_in (combinational).
- **BUF_DEPTH=2:** ready_out is registered and equals "skid entry empty".
  - When full (2 entries), ready_out=0.
  - A simultaneous pop and push keeps order.
  - Full throughput of 1 per cycle is sustained when ready_in=1.
- **Simultaneous flush and push:** the flush wins; valid_out=0 next cycle.
- **Reset mid-stream:** all buffered entries are lost.

## Configuration
- MSRV32_DEC_M_EXT_EN defined:
  - OP with funct7=0000001 is legal, muldiv_en_out=1, alu_opcode={1'b0, funct3}, rf_wr_en=1.
- MSRV32_DEC_M_EXT_EN undefined:
  - Same encoding is illegal and muldiv_en_out is tied to 0.

## Test plan
- Reset, then ADD 0x003100B3 with ready_in=1: valid_out one cycle after accept, alu_opcode=0000, rf_wr_en=1, alu_src=1, wb_mux_sel=000.
- SUB 0x403100B3, then SRAI 0x40315093: alu_opcode=1000, then 1101, with imm_type=001.
- LW 0x00012083 with iadder=10: misalligned_load=1, rf_wr_en=0. SH 0x00111023 with iadder=01: misalligned_store=1, mem_wr_req=0.
- MUL 0x023100B3:
  - With the macro: muldiv_en=1, illegal=0.
  - Without it: illegal=1 and illegal_count_out goes from 0 to 1.
  - 300 illegal accepts with CNT_W=8: count reads 255.
- BUF_DEPTH=2, ready_in=0, valid_in=1 for 3 cycles: two accepted, ready_out=0, third not accepted. Releasing ready_in delivers them in order.
- Two entries buffered, then trap_taken_in=1 with valid_in=1: valid_out=0 next cycle, nothing delivered, ready_out=1.

Source files
------------

// File: rtl/msrv32_dec_pipe_if.sv
// Fetch-to-decode input handshake and decode-to-execute control bundle of msrv32_dec_pipe.
interface msrv32_dec_pipe_if #(
  parameter int unsigned CNT_W = 8
);
  logic [31:0]      instr_in;
  logic [1:0]       iadder_1_to_0_in;
  logic             valid_in;
  logic             ready_out;
  logic             trap_taken_in;
  logic             valid_out;
  logic             ready_in;
  logic [3:0]       alu_opcode_out;
  logic             mem_wr_req_out;
  logic [1:0]       load_size_out;
  logic             load_unsigned_out;
  logic             alu_src_out;
  logic             iadder_src_out;
  logic             csr_wr_en_out;
  logic             rf_wr_en_out;
  logic [2:0]       wb_mux_sel_out;
  logic [2:0]       imm_type_out;
  logic [2:0]       csr_op_out;
  logic             illegal_instr_out;
  logic             misalligned_load_out;
  logic             misalligned_store_out;
  logic             muldiv_en_out;
  logic [CNT_W-1:0] illegal_count_out;

  modport master (
    output instr_in, iadder_1_to_0_in, valid_in, trap_taken_in, ready_in,
    input  ready_out, valid_out, alu_opcode_out, mem_wr_req_out, load_size_out,
           load_unsigned_out, alu_src_out, iadder_src_out, csr_wr_en_out, rf_wr_en_out,
           wb_mux_sel_out, imm_type_out, csr_op_out, illegal_instr_out,
           misalligned_load_out, misalligned_store_out, muldiv_en_out, illegal_count_out
  );

  modport slave (
    input  instr_in, iadder_1_to_0_in, valid_in, trap_taken_in, ready_in,
    output ready_out, valid_out, alu_opcode_out, mem_wr_req_out, load_size_out,
           load_unsigned_out, alu_src_out, iadder_src_out, csr_wr_en_out, rf_wr_en_out,
           wb_mux_sel_out, imm_type_out, csr_op_out, illegal_instr_out,
           misalligned_load_out, misalligned_store_out, muldiv_en_out, illegal_count_out
  );
endinterface

// File: rtl/msrv32_dec_pipe.sv
// Registered msrv32 decoder stage with valid/ready output buffer, trap flush and illegal counter.
// Define MSRV32_DEC_M_EXT_EN to decode RV32M (funct7=0000001 under OP).
module msrv32_dec_pipe #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned CNT_W     = 8
) (
  input logic               ms_riscv32_mp_clk_in,
  input logic               ms_riscv32_mp_rst_n_in,
  msrv32_dec_pipe_if.slave  dec
);
  typedef enum logic [4:0] {
    OPC_LOAD     = 5'b00000,
    OPC_MISC_MEM = 5'b00011,
    OPC_OP_IMM   = 5'b00100,
    OPC_AUIPC    = 5'b00101,
    OPC_STORE    = 5'b01000,
    OPC_OP       = 5'b01100,
    OPC_LUI      = 5'b01101,
    OPC_BRANCH   = 5'b11000,
    OPC_JALR     = 5'b11001,
    OPC_JAL      = 5'b11011,
    OPC_SYSTEM   = 5'b11100
  } opcode_e;

  typedef struct packed {
    logic [3:0] alu_opcode;
    logic       mem_wr_req;
    logic [1:0] load_size;
    logic       load_unsigned;
    logic       alu_src;
    logic       iadder_src;
    logic       csr_wr_en;
    logic       rf_wr_en;
    logic [2:0] wb_mux_sel;
    logic [2:0] imm_type;
    logic [2:0] csr_op;
    logic       illegal;
    logic       mis_load;
    logic       mis_store;
    logic       muldiv_en;
  } bundle_t;

  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [1:0] iadder;
  bundle_t    b;
  logic       legal_op, bad_f7, wr, is_load, is_store, size_mis;

  assign funct3 = dec.instr_in[14:12];
  assign funct7 = dec.instr_in[31:25];
  assign iadder = dec.iadder_1_to_0_in;

  always_comb begin
    b             = '0;
    legal_op      = 1'b1;
    bad_f7        = 1'b0;
    wr            = 1'b0;
    is_load       = 1'b0;
    is_store      = 1'b0;
    b.load_size     = funct3[1:0];
    b.load_unsigned = funct3[2];
    b.csr_op        = funct3;
    case (opcode_e'(dec.instr_in[6:2]))
      OPC_OP: begin
        b.alu_opcode = {dec.instr_in[30], funct3};
        b.alu_src    = 1'b1;
        wr           = 1'b1;
        if (funct7 == 7'b0000001) begin
`ifdef MSRV32_DEC_M_EXT_EN
          b.alu_opcode = {1'b0, funct3};
          b.muldiv_en  = 1'b1;
`else
          bad_f7 = 1'b1;
`endif
        end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
          bad_f7 = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        b.alu_opcode = {(funct3 == 3'b101) & dec.instr_in[30], funct3};
        b.imm_type   = 3'b001;
        wr           = 1'b1;
      end
      OPC_LOAD: begin
        is_load      = 1'b1;
        b.iadder_src = 1'b1;
        b.wb_mux_sel = 3'b001;
        b.imm_type   = 3'b001;
        wr           = 1'b1;
      end
      OPC_STORE: begin
        is_store     = 1'b1;
        b.iadder_src = 1'b1;
        b.imm_type   = 3'b010;
      end
      OPC_BRANCH: b.imm_type = 3'b011;
      OPC_JALR: begin
        b.iadder_src = 1'b1;
        b.wb_mux_sel = 3'b101;
        b.imm_type   = 3'b001;
        wr           = 1'b1;
      end
      OPC_JAL: begin
        b.wb_mux_sel = 3'b101;
        b.imm_type   = 3'b101;
        wr           = 1'b1;
      end
      OPC_LUI: begin
        b.wb_mux_sel = 3'b010;
        b.imm_type   = 3'b100;
        wr           = 1'b1;
      end
      OPC_AUIPC: begin
        b.wb_mux_sel = 3'b011;
        b.imm_type   = 3'b100;
        wr           = 1'b1;
      end
      OPC_SYSTEM: begin
        b.wb_mux_sel = 3'b100;
        b.imm_type   = 3'b110;
        b.csr_wr_en  = (funct3 != 3'b000);
        wr           = (funct3 != 3'b000);
      end
      OPC_MISC_MEM: ;
      default: legal_op = 1'b0;
    endcase
    size_mis     = ((funct3[1:0] == 2'b10) && (iadder != 2'b00)) ||
                   ((funct3[1:0] == 2'b01) && iadder[0]);
    b.illegal    = !legal_op || (dec.instr_in[1:0] != 2'b11) || bad_f7;
    b.mis_load   = is_load & size_mis;
    b.mis_store  = is_store & size_mis;
    b.rf_wr_en   = wr & !b.illegal & !b.mis_load;
    b.mem_wr_req = is_store & !b.mis_store & !b.illegal;
  end

  logic       ready, push, pop, main_valid;
  bundle_t    main_q;

  assign push = dec.valid_in & ready & !dec.trap_taken_in;
  assign pop  = main_valid & dec.ready_in;

  if (BUF_DEPTH == 1) begin : g_reg
    assign ready = !main_valid | dec.ready_in;
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
        main_valid <= 1'b0;
        main_q     <= '0;
      end else if (dec.trap_taken_in) begin
        main_valid <= 1'b0;
      end else if (push) begin
        main_valid <= 1'b1;
        main_q     <= b;
      end else if (pop) begin
        main_valid <= 1'b0;
      end
    end
  end else begin : g_skid
    // Any depth other than 1 builds the two-entry skid; ready is the registered "skid empty".
    logic    skid_valid;
    bundle_t skid_q;
    assign ready = !skid_valid;
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
      if (!ms_riscv32_mp_rst_n_in) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        main_q     <= '0;
        skid_q     <= '0;
      end else if (dec.trap_taken_in) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (skid_valid) begin
        if (pop) begin
          main_q     <= skid_q;
          skid_valid <= 1'b0;
        end
      end else if (!main_valid || pop) begin
        main_valid <= push;
        if (push) main_q <= b;
      end else if (push) begin
        skid_q     <= b;
        skid_valid <= 1'b1;
      end
    end
  end

  logic [CNT_W-1:0] cnt;
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) cnt <= '0;
    else if (push && b.illegal && cnt != '1) cnt <= cnt + 1'b1;
  end

  assign dec.ready_out             = ready;
  assign dec.valid_out             = main_valid;
  assign dec.alu_opcode_out        = main_q.alu_opcode;
  assign dec.mem_wr_req_out        = main_q.mem_wr_req;
  assign dec.load_size_out         = main_q.load_size;
  assign dec.load_unsigned_out     = main_q.load_unsigned;
  assign dec.alu_src_out           = main_q.alu_src;
  assign dec.iadder_src_out        = main_q.iadder_src;
  assign dec.csr_wr_en_out         = main_q.csr_wr_en;
  assign dec.rf_wr_en_out          = main_q.rf_wr_en;
  assign dec.wb_mux_sel_out        = main_q.wb_mux_sel;
  assign dec.imm_type_out          = main_q.imm_type;
  assign dec.csr_op_out            = main_q.csr_op;
  assign dec.illegal_instr_out     = main_q.illegal;
  assign dec.misalligned_load_out  = main_q.mis_load;
  assign dec.misalligned_store_out = main_q.mis_store;
  assign dec.muldiv_en_out         = main_q.muldiv_en;
  assign dec.illegal_count_out     = cnt;
endmodule

// File: tb/tb_msrv32_dec_pipe.sv
// Directed bench for msrv32_dec_pipe: skid-buffer instance plus a single-register instance.
module tb_msrv32_dec_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;
  int   prev;

  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] SUB   = 32'h403100B3;
  localparam logic [31:0] SRAI  = 32'h40315093;
  localparam logic [31:0] LW    = 32'h00012083;
  localparam logic [31:0] SH    = 32'h00111023;
  localparam logic [31:0] LUI   = 32'h123450B7;
  localparam logic [31:0] JAL   = 32'h0080006F;
  localparam logic [31:0] CSRRW = 32'h30029073;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] MUL   = 32'h023100B3;
  localparam logic [31:0] ADDI  = 32'h00100093;
  localparam logic [31:0] XORI  = 32'h00104093;
  localparam logic [31:0] ORI   = 32'h00106093;

  always #5 clk = ~clk;

  msrv32_dec_pipe_if #(.CNT_W(8)) bi ();
  msrv32_dec_pipe_if #(.CNT_W(8)) b1 ();

  msrv32_dec_pipe #(.BUF_DEPTH(2), .CNT_W(8)) dut2 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n), .dec(bi));
  msrv32_dec_pipe #(.BUF_DEPTH(1), .CNT_W(8)) dut1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_n_in(rst_n), .dec(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] i, input logic [1:0] a);
    bi.instr_in         = i;
    bi.iadder_1_to_0_in = a;
    bi.valid_in         = 1'b1;
    tick();
    bi.valid_in         = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bi.instr_in = '0; bi.iadder_1_to_0_in = '0; bi.valid_in = 1'b0;
    bi.trap_taken_in = 1'b0; bi.ready_in = 1'b1;
    b1.instr_in = '0; b1.iadder_1_to_0_in = '0; b1.valid_in = 1'b0;
    b1.trap_taken_in = 1'b0; b1.ready_in = 1'b0;
    #12;
    chk("rst_valid", bi.valid_out, 0);
    chk("rst_ready", bi.ready_out, 1);
    chk("rst_alu", bi.alu_opcode_out, 0);
    chk("rst_rf", bi.rf_wr_en_out, 0);
    chk("rst_wb", bi.wb_mux_sel_out, 0);
    chk("rst_cnt", bi.illegal_count_out, 0);
    chk("rst1_ready", b1.ready_out, 1);
    rst_n = 1'b1;
    tick();

    chk("add_pre_valid", bi.valid_out, 0);
    send(ADD, 2'b00);
    chk("add_valid", bi.valid_out, 1);
    chk("add_alu", bi.alu_opcode_out, 4'b0000);
    chk("add_rf", bi.rf_wr_en_out, 1);
    chk("add_src", bi.alu_src_out, 1);
    chk("add_wb", bi.wb_mux_sel_out, 3'b000);
    chk("add_ill", bi.illegal_instr_out, 0);
    send(SUB, 2'b00);
    chk("sub_alu", bi.alu_opcode_out, 4'b1000);
    send(SRAI, 2'b00);
    chk("srai_alu", bi.alu_opcode_out, 4'b1101);
    chk("srai_imm", bi.imm_type_out, 3'b001);
    chk("srai_src", bi.alu_src_out, 0);
    send(LW, 2'b10);
    chk("lw_misld", bi.misalligned_load_out, 1);
    chk("lw_rf", bi.rf_wr_en_out, 0);
    chk("lw_size", bi.load_size_out, 2'b10);
    chk("lw_wb", bi.wb_mux_sel_out, 3'b001);
    chk("lw_isrc", bi.iadder_src_out, 1);
    send(LW, 2'b00);
    chk("lw_ok_mis", bi.misalligned_load_out, 0);
    chk("lw_ok_rf", bi.rf_wr_en_out, 1);
    send(SH, 2'b01);
    chk("sh_misst", bi.misalligned_store_out, 1);
    chk("sh_memwr", bi.mem_wr_req_out, 0);
    chk("sh_imm", bi.imm_type_out, 3'b010);
    send(SH, 2'b10);
    chk("sh_ok_mis", bi.misalligned_store_out, 0);
    chk("sh_ok_memwr", bi.mem_wr_req_out, 1);
    send(LUI, 2'b00);
    chk("lui_wb", bi.wb_mux_sel_out, 3'b010);
    chk("lui_imm", bi.imm_type_out, 3'b100);
    send(JAL, 2'b00);
    chk("jal_wb", bi.wb_mux_sel_out, 3'b101);
    chk("jal_imm", bi.imm_type_out, 3'b101);
    send(CSRRW, 2'b00);
    chk("csr_wren", bi.csr_wr_en_out, 1);
    chk("csr_op", bi.csr_op_out, 3'b001);
    chk("csr_wb", bi.wb_mux_sel_out, 3'b100);
    chk("csr_imm", bi.imm_type_out, 3'b110);
    chk("csr_rf", bi.rf_wr_en_out, 1);
    send(BEQ, 2'b00);
    chk("beq_imm", bi.imm_type_out, 3'b011);
    chk("beq_rf", bi.rf_wr_en_out, 0);

    chk("mul_cnt_pre", bi.illegal_count_out, 0);
    send(MUL, 2'b00);
`ifdef MSRV32_DEC_M_EXT_EN
    prev = 0;
    chk("mul_muldiv", bi.muldiv_en_out, 1);
    chk("mul_ill", bi.illegal_instr_out, 0);
    chk("mul_rf", bi.rf_wr_en_out, 1);
    chk("mul_cnt", bi.illegal_count_out, 0);
`else
    prev = 1;
    chk("mul_muldiv", bi.muldiv_en_out, 0);
    chk("mul_ill", bi.illegal_instr_out, 1);
    chk("mul_rf", bi.rf_wr_en_out, 0);
    chk("mul_cnt", bi.illegal_count_out, 1);
`endif

    bi.instr_in = 32'h0; bi.iadder_1_to_0_in = 2'b00; bi.valid_in = 1'b1;
    repeat (254 - prev) tick();
    chk("sat_254", bi.illegal_count_out, 254);
    chk("sat_ill", bi.illegal_instr_out, 1);
    tick();
    chk("sat_255", bi.illegal_count_out, 255);
    repeat (45) tick();
    chk("sat_hold", bi.illegal_count_out, 255);
    bi.valid_in = 1'b0;
    tick();
    chk("drain_valid", bi.valid_out, 0);

    bi.ready_in = 1'b0; bi.valid_in = 1'b1; bi.instr_in = ADDI;
    chk("bp_rdy0", bi.ready_out, 1);
    tick();
    bi.instr_in = XORI;
    chk("bp_rdy1", bi.ready_out, 1);
    chk("bp_v1", bi.valid_out, 1);
    tick();
    bi.instr_in = ORI;
    chk("bp_full", bi.ready_out, 0);
    tick();
    chk("bp_hold_v", bi.valid_out, 1);
    chk("bp_hold_alu", bi.alu_opcode_out, 4'b0000);
    chk("bp_still_full", bi.ready_out, 0);
    bi.valid_in = 1'b0; bi.ready_in = 1'b1;
    tick();
    chk("bp_second_v", bi.valid_out, 1);
    chk("bp_second_alu", bi.alu_opcode_out, 4'b0100);
    chk("bp_rdy_back", bi.ready_out, 1);
    tick();
    chk("bp_no_third", bi.valid_out, 0);

    bi.valid_in = 1'b1; bi.instr_in = ADDI;
    tick();
    bi.instr_in = XORI;
    chk("tp_a", bi.alu_opcode_out, 4'b0000);
    tick();
    bi.instr_in = ORI;
    chk("tp_b", bi.alu_opcode_out, 4'b0100);
    chk("tp_b_rdy", bi.ready_out, 1);
    tick();
    bi.valid_in = 1'b0;
    chk("tp_c", bi.alu_opcode_out, 4'b0110);
    chk("tp_c_v", bi.valid_out, 1);
    tick();
    chk("tp_end", bi.valid_out, 0);

    bi.ready_in = 1'b0; bi.valid_in = 1'b1; bi.instr_in = ADDI;
    tick();
    bi.instr_in = XORI;
    tick();
    chk("fl_full", bi.ready_out, 0);
    bi.trap_taken_in = 1'b1; bi.instr_in = ORI;
    tick();
    bi.trap_taken_in = 1'b0; bi.valid_in = 1'b0;
    chk("fl_valid", bi.valid_out, 0);
    chk("fl_ready", bi.ready_out, 1);
    bi.ready_in = 1'b1;
    tick();
    chk("fl_nothing", bi.valid_out, 0);
    bi.trap_taken_in = 1'b1; bi.valid_in = 1'b1; bi.instr_in = ADDI;
    tick();
    bi.trap_taken_in = 1'b0; bi.valid_in = 1'b0;
    chk("fl_push_lost", bi.valid_out, 0);
    chk("fl_cnt_kept", bi.illegal_count_out, 255);

    b1.valid_in = 1'b1; b1.instr_in = XORI;
    chk("d1_rdy_empty", b1.ready_out, 1);
    tick();
    b1.valid_in = 1'b0;
    chk("d1_valid", b1.valid_out, 1);
    chk("d1_alu", b1.alu_opcode_out, 4'b0100);
    chk("d1_rdy_full", b1.ready_out, 0);
    tick();
    chk("d1_hold", b1.alu_opcode_out, 4'b0100);
    b1.ready_in = 1'b1;
    #1;
    chk("d1_rdy_comb", b1.ready_out, 1);
    b1.valid_in = 1'b1; b1.instr_in = ORI;
    tick();
    b1.valid_in = 1'b0;
    chk("d1_next", b1.alu_opcode_out, 4'b0110);
    chk("d1_next_v", b1.valid_out, 1);
    tick();
    chk("d1_empty", b1.valid_out, 0);
    b1.valid_in = 1'b1; b1.trap_taken_in = 1'b1; b1.instr_in = ADDI;
    tick();
    b1.valid_in = 1'b0; b1.trap_taken_in = 1'b0;
    chk("d1_flush", b1.valid_out, 0);

    bi.ready_in = 1'b0; bi.valid_in = 1'b1; bi.instr_in = XORI;
    tick();
    tick();
    bi.valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", bi.valid_out, 0);
    chk("mr_ready", bi.ready_out, 1);
    chk("mr_alu", bi.alu_opcode_out, 0);
    chk("mr_cnt", bi.illegal_count_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bi.ready_in = 1'b1;
    tick();
    chk("mr_after", bi.valid_out, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
